// File: rtl/acc2_core.sv
// acc2_core: accumulator CPU core with a req/ack memory port, an 8-opcode ISA and
// a step gate that is either a manual pulse or a free-running timer in auto mode.
module acc2_core #(
  parameter int              AW        = 12,
  parameter int              DW        = 16,
  parameter logic [AW-1:0]   BOOT_ADDR = 12'h800,
  parameter logic [DW-1:0]   G_INIT    = 16'hAA00,
  parameter int              TBITS     = 24
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          step,
  input  logic          mode_tgl,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [DW-1:0] g_out,
  output logic [DW-1:0] a_out,
  output logic [AW-1:0] s_out,
  output logic          mode,
  output logic          halted
);

  typedef enum logic [2:0] {
    ST_WAIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_TCF = 3'b001;
  localparam logic [2:0] OP_BZF = 3'b010;
  localparam logic [2:0] OP_CA  = 3'b011;
  localparam logic [2:0] OP_CS  = 3'b100;
  localparam logic [2:0] OP_TS  = 3'b101;
  localparam logic [2:0] OP_AD  = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  state_t           state;
  logic [TBITS-1:0] timer;
  logic [2:0]       opc;
  logic [AW-1:0]    g_addr;
  logic             timer_done;
  logic             trig;
  logic             xfer;
  logic             mode_flip;

  assign opc        = g_out[DW-2:DW-4];
  assign g_addr     = g_out[AW-1:0];
  assign timer_done = (state == ST_WAIT) && mode && (timer == '1);
  // trig reads the current mode register, so a same-cycle toggle applies to the next WAIT decision
  assign trig       = mode ? timer_done : step;
  // ack only counts while a request is actually outstanding
  assign xfer       = mem_req && mem_ack;
  assign mode_flip  = mode_tgl && (state != ST_HALT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_WAIT;
      timer     <= '0;
      mode      <= 1'b0;
      halted    <= 1'b0;
      s_out     <= BOOT_ADDR;
      g_out     <= G_INIT;
      a_out     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (mode_flip) mode <= ~mode;

      if ((state != ST_WAIT) || !mode || mode_flip || timer_done) timer <= '0;
      else                                                        timer <= timer + 1'b1;

      case (state)
        ST_WAIT: begin
          if (trig) begin
            state    <= ST_FETCH;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= s_out;
          end
        end
        ST_FETCH: begin
          if (xfer) begin
            g_out   <= mem_rdata;
            s_out   <= s_out + 1'b1;
            mem_req <= 1'b0;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (opc)
            OP_NOP: state <= ST_WAIT;
            OP_TCF: begin
              s_out <= g_addr;
              state <= ST_WAIT;
            end
            OP_BZF: begin
              if (a_out == '0) s_out <= g_addr;
              state <= ST_WAIT;
            end
            OP_TS: begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= g_addr;
              mem_wdata <= a_out;
              state     <= ST_MEM;
            end
            OP_HLT: begin
              halted <= 1'b1;
              state  <= ST_HALT;
            end
            default: begin
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= g_addr;
              state    <= ST_MEM;
            end
          endcase
        end
        ST_MEM: begin
          if (xfer) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            case (opc)
              OP_CA:   a_out <= mem_rdata;
              OP_CS:   a_out <= ~mem_rdata;
              OP_AD:   a_out <= a_out + mem_rdata;
              default: a_out <= a_out;
            endcase
            state <= ST_WAIT;
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_acc2_core.sv
// Directed bench for acc2_core: behavioural memory with programmable ack delay,
// a table of single-instruction vectors and hand-written multi-cycle sequences.
module tb_acc2_core;
  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rstn, step, mode_tgl, force_ack;
  logic          mem_req, mem_we, mem_ack, mode, halted;
  logic [AW-1:0] mem_addr, s_out;
  logic [DW-1:0] mem_wdata, mem_rdata, g_out, a_out;

  always #5 clk = ~clk;

  acc2_core #(.AW(AW), .DW(DW), .BOOT_ADDR(12'h800), .G_INIT(16'hAA00), .TBITS(4)) dut (
    .clk(clk), .rstn(rstn), .step(step), .mode_tgl(mode_tgl),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .g_out(g_out), .a_out(a_out), .s_out(s_out), .mode(mode), .halted(halted)
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int ack_delay = 0;
  int wait_cnt  = 0;
  int txn_cnt   = 0;

  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = force_ack | (mem_req && (wait_cnt >= ack_delay));

  always @(posedge clk) begin
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
  end

  always @(posedge clk) begin
    if (mem_req && mem_ack) begin
      txn_cnt = txn_cnt + 1;
      if (mem_we) mem[mem_addr] = mem_wdata;
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  typedef struct {
    logic [11:0] pc;
    logic [15:0] instr;
    logic [11:0] op_a;
    logic [15:0] op_d;
    logic [15:0] exp_a;
    logic [11:0] exp_s;
  } vec_t;

  vec_t vt [12];

  initial begin
    int tc0;
    int nf;
    int t [4];
    logic prev;

    vt[0]  = '{12'h805, 16'h3010, 12'h010, 16'h7FFF, 16'h7FFF, 12'h806};
    vt[1]  = '{12'h806, 16'h6011, 12'h011, 16'h8003, 16'h0002, 12'h807};
    vt[2]  = '{12'h807, 16'h5012, 12'h012, 16'hDEAD, 16'h0002, 12'h808};
    vt[3]  = '{12'h808, 16'h2100, 12'h0FF, 16'h0000, 16'h0002, 12'h809};
    vt[4]  = '{12'h809, 16'h4013, 12'h013, 16'h00FF, 16'hFF00, 12'h80A};
    vt[5]  = '{12'h80A, 16'h3014, 12'h014, 16'h0000, 16'h0000, 12'h80B};
    vt[6]  = '{12'h80B, 16'h2820, 12'h0FF, 16'h0000, 16'h0000, 12'h820};
    vt[7]  = '{12'h820, 16'h3015, 12'h015, 16'h0001, 16'h0001, 12'h821};
    vt[8]  = '{12'h821, 16'h2100, 12'h0FF, 16'h0000, 16'h0001, 12'h822};
    vt[9]  = '{12'h822, 16'h8000, 12'h0FF, 16'h0000, 16'h0001, 12'h823};
    vt[10] = '{12'h823, 16'hB016, 12'h016, 16'h1234, 16'h1234, 12'h824};
    vt[11] = '{12'h824, 16'h6017, 12'h017, 16'hEDCC, 16'h0000, 12'h825};

    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[12'h800] = 16'h1805;
    for (int i = 0; i < 12; i++) begin
      mem[vt[i].pc]   = vt[i].instr;
      mem[vt[i].op_a] = vt[i].op_d;
    end

    rstn = 1'b0; step = 1'b0; mode_tgl = 1'b0; force_ack = 1'b0;
    run(3);
    chk("rst_s", s_out, 12'h800);
    chk("rst_g", g_out, 16'hAA00);
    chk("rst_a", a_out, 16'h0000);
    chk("rst_mode", mode, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_req", mem_req, 1'b0);
    rstn = 1'b1;
    run(2);

    // TCF 0x805: fetch in the cycle after step, G/S one cycle later, jump the next
    tc0 = txn_cnt;
    pulse_step();
    chk("tcf_req", mem_req, 1'b1);
    chk("tcf_addr", mem_addr, 12'h800);
    chk("tcf_we", mem_we, 1'b0);
    tick();
    chk("tcf_g", g_out, 16'h1805);
    chk("tcf_s_inc", s_out, 12'h801);
    chk("tcf_req_drop", mem_req, 1'b0);
    tick();
    chk("tcf_s_jump", s_out, 12'h805);
    chk("tcf_reads", txn_cnt - tc0, 1);

    // Vector 0 steps immediately: core must already be back in WAIT
    for (int i = 0; i < 12; i++) begin
      pulse_step();
      chk($sformatf("v%0d_req", i), mem_req, 1'b1);
      chk($sformatf("v%0d_faddr", i), mem_addr, vt[i].pc);
      run(7);
      chk($sformatf("v%0d_a", i), a_out, vt[i].exp_a);
      chk($sformatf("v%0d_s", i), s_out, vt[i].exp_s);
      chk($sformatf("v%0d_g", i), g_out, vt[i].instr);
    end
    chk("ts_write", mem[12'h012], 16'h0002);

    // Ack with no request outstanding must not disturb anything
    tc0 = txn_cnt;
    force_ack = 1'b1;
    run(3);
    force_ack = 1'b0;
    chk("idle_ack_s", s_out, 12'h825);
    chk("idle_ack_g", g_out, 16'h6017);
    chk("idle_ack_txn", txn_cnt - tc0, 0);

    // Slow memory: ack 5 cycles late, extra step during FETCH is dropped
    ack_delay = 5;
    mem[12'h825] = 16'h3018;
    mem[12'h018] = 16'h5A5A;
    tc0 = txn_cnt;
    pulse_step();
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("slow_req%0d", k), mem_req, 1'b1);
      chk($sformatf("slow_addr%0d", k), mem_addr, 12'h825);
      chk($sformatf("slow_we%0d", k), mem_we, 1'b0);
      step = (k == 1);
      tick();
      step = 1'b0;
    end
    run(20);
    chk("slow_a", a_out, 16'h5A5A);
    chk("slow_s", s_out, 12'h826);
    chk("slow_txn", txn_cnt - tc0, 2);

    // Auto mode with TBITS=4: NOP fetched every 16 WAIT cycles (+FETCH+EXEC)
    ack_delay = 0;
    mode_tgl = 1'b1;
    tick();
    mode_tgl = 1'b0;
    chk("auto_mode", mode, 1'b1);
    nf = 0;
    prev = mem_req;
    for (int c = 1; c <= 120 && nf < 4; c++) begin
      tick();
      if (mem_req && !prev) begin
        t[nf] = c;
        nf = nf + 1;
      end
      prev = mem_req;
    end
    chk("auto_nfetch", nf, 4);
    chk("auto_first", t[0], 16);
    for (int i = 0; i < 3; i++) chk($sformatf("auto_period%0d", i), t[i+1] - t[i], 18);
    mode_tgl = 1'b1;
    tick();
    mode_tgl = 1'b0;
    chk("manual_mode", mode, 1'b0);
    run(5);
    chk("auto_s", s_out, 12'h82A);

    // HLT (bit 15 set, ignored): terminal, no requests, toggles ignored
    mem[12'h82A] = 16'hF000;
    pulse_step();
    run(5);
    chk("hlt_halted", halted, 1'b1);
    chk("hlt_s", s_out, 12'h82B);
    chk("hlt_g", g_out, 16'hF000);
    tc0 = txn_cnt;
    repeat (4) begin
      pulse_step();
      mode_tgl = 1'b1;
      tick();
      mode_tgl = 1'b0;
      run(20);
    end
    chk("hlt_txn", txn_cnt - tc0, 0);
    chk("hlt_req", mem_req, 1'b0);
    chk("hlt_mode", mode, 1'b0);
    chk("hlt_s_hold", s_out, 12'h82B);
    chk("hlt_a_hold", a_out, 16'h5A5A);

    // Reset mid-FETCH: request drops at once, late ack ignored
    rstn = 1'b0;
    run(2);
    rstn = 1'b1;
    run(2);
    chk("rst2_halted", halted, 1'b0);
    ack_delay = 10;
    pulse_step();
    run(2);
    chk("midf_req", mem_req, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    chk("midf_req_drop", mem_req, 1'b0);
    chk("midf_s", s_out, 12'h800);
    chk("midf_g", g_out, 16'hAA00);
    chk("midf_a", a_out, 16'h0000);
    run(3);
    rstn = 1'b1;
    run(15);
    chk("post_req", mem_req, 1'b0);
    chk("post_s", s_out, 12'h800);
    chk("post_g", g_out, 16'hAA00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
